// File: rtl/demux_1n_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output registers.
// Optional saturating drop counter for out-of-range beats: define DEMUX_DROP_CNT_EN.
module demux_1n_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               auto,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic [SEL_W-1:0]   ptr,
   output logic [7:0]         drop_cnt
);

   logic [SEL_W-1:0]   tgt;
   logic               in_range;
   logic               accept;
   logic [N-1:0]       load;
   logic [N-1:0]       valid_q;
   logic [N*WIDTH-1:0] data_q;
   logic [SEL_W-1:0]   ptr_q;

   // Out-of-range targets are always accepted so a bad select cannot stall the producer.
   always_comb begin
      tgt      = auto ? ptr_q : in_sel;
      in_range = (32'(tgt) < 32'(N));
      in_ready = 1'b0;
      load     = '0;
      if (!rst) begin
         if (!in_range)
            in_ready = 1'b1;
         else
            in_ready = ~valid_q[tgt] | out_ready[tgt];
         if (in_valid && in_ready && in_range)
            load[tgt] = 1'b1;
      end
      accept = in_valid & in_ready;
   end

   for (genvar k = 0; k < N; k++) begin : g_chan
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q[k]                 <= 1'b0;
            data_q[k*WIDTH +: WIDTH]   <= '0;
         end else if (load[k]) begin
            valid_q[k]                 <= 1'b1;
            data_q[k*WIDTH +: WIDTH]   <= in_data;
         end else if (out_ready[k]) begin
            valid_q[k]                 <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else if (accept && in_range && auto)
         ptr_q <= (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + 1'b1;
   end

`ifdef DEMUX_DROP_CNT_EN
   logic [7:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst)
         drop_q <= '0;
      else if (accept && !in_range && drop_q != 8'hFF)
         drop_q <= drop_q + 8'd1;
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux_1n_stream.sv
// Scoreboard bench for demux_1n_stream: N=8 instance for routing/backpressure/sweep/reset,
// N=6 instance for out-of-range handling and the drop counter.
module tb_demux_1n_stream;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [2:0]  in_sel;
   logic        auto_i;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [63:0] out_data;
   logic [2:0]  ptr;
   logic [7:0]  drop_cnt;

   logic        in_valid6;
   logic        in_ready6;
   logic [7:0]  in_data6;
   logic [2:0]  in_sel6;
   logic [5:0]  out_valid6;
   logic [5:0]  out_ready6;
   logic [47:0] out_data6;
   logic [2:0]  ptr6;
   logic [7:0]  drop_cnt6;

   int unsigned tests  = 0;
   int unsigned failed = 0;

   logic [7:0]  exp_q[8][$];
   logic [2:0]  mptr;
   logic [7:0]  exp_ov;
   bit          chk_ov;

   always #5 clk = ~clk;

   demux_1n_stream #(.WIDTH(8), .N(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .auto(auto_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ptr(ptr), .drop_cnt(drop_cnt)
   );

   demux_1n_stream #(.WIDTH(8), .N(6)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
      .in_data(in_data6), .in_sel(in_sel6), .auto(1'b0),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
      .ptr(ptr6), .drop_cnt(drop_cnt6)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every beat a consumer takes at the next edge is compared with the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 8; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  tests++;
                  failed++;
                  $display("FAIL unexpected_beat ch%0d: got 0x%0h expected none", k, out_data[k*8 +: 8]);
               end else begin
                  check($sformatf("data_ch%0d", k), 32'(out_data[k*8 +: 8]), 32'(exp_q[k].pop_front()));
               end
            end
         end
      end
   end

   task automatic flush_model();
      for (int k = 0; k < 8; k++) exp_q[k].delete();
      mptr = '0;
   endtask

   // Present one beat; waits (bounded) for acceptance, records the expected beat.
   task automatic send(input logic [2:0] sel, input logic [7:0] data, input bit au,
                       output int unsigned waited);
      logic [2:0] tgt;
      waited   = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      auto_i   = au;
      @(negedge clk);
      if (chk_ov) check("out_valid_onehot", 32'(out_valid), 32'(exp_ov));
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         tests++;
         failed++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end else begin
         tgt = au ? mptr : sel;
         exp_q[tgt].push_back(data);
         if (au) mptr = (mptr == 3'd7) ? 3'd0 : mptr + 3'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int unsigned w;
      int unsigned bad_rdy;
      int unsigned bad_ov;

      rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_sel = 3'd1; auto_i = 1'b0;
      out_ready = 8'hFF; in_valid6 = 1'b0; in_data6 = '0; in_sel6 = '0; out_ready6 = '1;
      chk_ov = 1'b0; exp_ov = '0;
      flush_model();

      // Reset held two cycles with in_valid asserted
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", 32'(in_ready), 32'd0);
      end
      check("rst_out_valid", 32'(out_valid), 32'h00);
      check("rst_ptr", 32'(ptr), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_out_data", out_data[31:0], 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Explicit routing, back-to-back, all consumers ready
      for (int k = 0; k < 8; k++) begin
         chk_ov = (k > 0);
         exp_ov = (k > 0) ? (8'h01 << (k - 1)) : 8'h00;
         send(3'(k), 8'hA0 + 8'(k), 1'b0, w);
         check($sformatf("route_stall_k%0d", k), w, 32'd0);
      end
      chk_ov = 1'b0;
      @(negedge clk);
      check("route_last_valid", 32'(out_valid), 32'h80);
      check("route_last_data", 32'(out_data[63:56]), 32'hA7);
      @(posedge clk); #1;

      // Backpressure on channel 3
      out_ready = 8'hF7;
      send(3'd3, 8'h11, 1'b0, w);
      in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h22;
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_held_data", 32'(out_data[31:24]), 32'h11);
      @(posedge clk); #1;
      out_ready = 8'hFF;
      @(negedge clk);
      check("bp_in_ready_pass", 32'(in_ready), 32'd1);
      exp_q[3].push_back(8'h22);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_no_bubble", 32'(out_valid), 32'h08);
      check("bp_new_data", 32'(out_data[31:24]), 32'h22);
      @(posedge clk); #1;

      // Auto sweep: in_sel held at 5 and must be ignored
      for (int i = 0; i < 10; i++) begin
         chk_ov = (i > 0);
         exp_ov = (i > 0) ? (8'h01 << ((i - 1) % 8)) : 8'h00;
         send(3'd5, 8'(i), 1'b1, w);
      end
      chk_ov = 1'b0;
      @(negedge clk);
      check("sweep_last_valid", 32'(out_valid), 32'h02);
      check("sweep_ptr", 32'(ptr), 32'd2);
      @(posedge clk); #1;

      // Out-of-range on the N=6 instance
      bad_rdy = 0; bad_ov = 0;
      in_valid6 = 1'b1; in_sel6 = 3'd7;
      for (int i = 0; i < 300; i++) begin
         in_data6 = 8'(i);
         @(negedge clk);
         if (in_ready6 !== 1'b1) bad_rdy++;
         if (out_valid6 !== 6'h00) bad_ov++;
         @(posedge clk); #1;
      end
      in_valid6 = 1'b0;
      check("oor_in_ready_low_cycles", bad_rdy, 32'd0);
      check("oor_out_valid_cycles", bad_ov, 32'd0);
      @(negedge clk);
`ifdef DEMUX_DROP_CNT_EN
      check("oor_drop_cnt", 32'(drop_cnt6), 32'd255);
`else
      check("oor_drop_cnt", 32'(drop_cnt6), 32'd0);
`endif
      check("oor_ptr6", 32'(ptr6), 32'd0);
      @(posedge clk); #1;
      in_valid6 = 1'b1; in_sel6 = 3'd5; in_data6 = 8'h6B;
      @(posedge clk); #1;
      in_valid6 = 1'b0;
      @(negedge clk);
      check("n6_ch5_valid", 32'(out_valid6), 32'h20);
      check("n6_ch5_data", 32'(out_data6[47:40]), 32'h6B);
      @(posedge clk); #1;

      // Mid-operation reset with channels 0,2,5 full
      out_ready = 8'hDA;
      send(3'd0, 8'h30, 1'b0, w);
      send(3'd2, 8'h32, 1'b0, w);
      send(3'd5, 8'h35, 1'b0, w);
      @(negedge clk);
      check("mid_full_valid", 32'(out_valid), 32'h25);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1; in_sel = 3'd4; in_data = 8'hEE;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      flush_model();
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'h00);
      check("mid_rst_ptr", 32'(ptr), 32'd0);
      check("mid_rst_drop6", 32'(drop_cnt6), 32'd0);
      @(posedge clk); #1;
      send(3'd2, 8'h77, 1'b0, w);
      @(negedge clk);
      check("mid_post_valid", 32'(out_valid), 32'h04);
      @(posedge clk); #1;
      out_ready = 8'hFF;

      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++)
         check($sformatf("leftover_ch%0d", k), exp_q[k].size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
